// File: rtl/adder_pkg.sv
// Shared defaults and helper functions for the pipelined adder.
// The subtract option is enabled by defining PIPE_ADDER_SUB_EN.
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Legal configuration: width splits into equal, non-empty chunks.
  function automatic bit width_ok(input int width, input int stages);
    return (stages > 0) && (width % stages == 0) && (width / stages >= 1);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CW-bit adder slice; one instance per pipeline stage.
module adder_chunk #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] sum,
  output logic          co
);

  assign {co, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, ci};

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder, one CW-bit chunk per stage, valid/ready with global advance.
// Optional subtract mode (sub port) when PIPE_ADDER_SUB_EN is defined.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Carry_In,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry_Out
);

  localparam int CW = chunk_w(WIDTH, STAGES);
  localparam int BQ = (STAGES > 1) ? STAGES - 1 : 1;

  if (!width_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  logic [WIDTH-1:0] a_in_d, a_in_q, b_in_d, b_in_q;
  logic             cin_in_d, cin_in_q, vld_in_d, vld_in_q;

  // acc holds finished sum chunks below and untouched operand-A chunks above
  logic [WIDTH-1:0] acc_d [STAGES];
  logic [WIDTH-1:0] acc_q [STAGES];
  logic [WIDTH-1:0] b_d   [BQ];
  logic [WIDTH-1:0] b_q   [BQ];
  logic [STAGES-1:0] cy_d, cy_q, vld_d, vld_q;

  logic [WIDTH-1:0] a_src [STAGES];
  logic [WIDTH-1:0] b_src [STAGES];
  logic [CW-1:0]    sum_c [STAGES];
  logic [STAGES-1:0] c_src, v_src, co_c;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

`ifdef PIPE_ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : Carry_In;
`else
  assign b_eff   = b;
  assign cin_eff = Carry_In;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign a_src[k] = a_in_q;
      assign b_src[k] = b_in_q;
      assign c_src[k] = cin_in_q;
      assign v_src[k] = vld_in_q;
    end else begin : g_next
      assign a_src[k] = acc_q[k-1];
      assign b_src[k] = b_q[k-1];
      assign c_src[k] = cy_q[k-1];
      assign v_src[k] = vld_q[k-1];
    end

    adder_chunk #(.CW(CW)) u_chunk (
      .a  (a_src[k][k*CW +: CW]),
      .b  (b_src[k][k*CW +: CW]),
      .ci (c_src[k]),
      .sum(sum_c[k]),
      .co (co_c[k])
    );
  end

  always_comb begin
    a_in_d   = a;
    b_in_d   = b_eff;
    cin_in_d = cin_eff;
    vld_in_d = in_valid;
    cy_d     = co_c;
    vld_d    = v_src;
    for (int k = 0; k < STAGES; k++) begin
      acc_d[k]              = a_src[k];
      acc_d[k][k*CW +: CW]  = sum_c[k];
    end
    for (int k = 0; k < BQ; k++) begin
      b_d[k] = b_src[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_in_q   <= '0;
      b_in_q   <= '0;
      cin_in_q <= 1'b0;
      vld_in_q <= 1'b0;
      cy_q     <= '0;
      vld_q    <= '0;
      for (int k = 0; k < STAGES; k++) acc_q[k] <= '0;
      for (int k = 0; k < BQ; k++)     b_q[k]   <= '0;
    end else if (advance) begin
      a_in_q   <= a_in_d;
      b_in_q   <= b_in_d;
      cin_in_q <= cin_in_d;
      vld_in_q <= vld_in_d;
      cy_q     <= cy_d;
      vld_q    <= vld_d;
      for (int k = 0; k < STAGES; k++) acc_q[k] <= acc_d[k];
      for (int k = 0; k < BQ; k++)     b_q[k]   <= b_d[k];
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign Sum       = acc_q[STAGES-1];
  assign Carry_Out = cy_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: random and directed operands against an arithmetic model.
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         Carry_In;
  logic         sub_v;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Sum;
  logic         Carry_Out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit done;

  logic [W:0] exp_q[$];
  int         pop_cyc[$];

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .Carry_In (Carry_In),
`ifdef PIPE_ADDER_SUB_EN
    .sub      (sub_v),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Sum      (Sum),
    .Carry_Out(Carry_Out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic sb);
    logic [W:0] r;
    if (sb) begin
      r[W-1:0] = x - y;
      r[W]     = (x >= y);
    end else begin
      r = x + y + ci;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic sb);
    int n = 0;
    bit ok = 1'b1;
    a = x; b = y; Carry_In = ci; sub_v = sb; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        total++; bad++; ok = 1'b0;
        $display("FAIL send_timeout: got in_ready=0 want 1");
        break;
      end
      @(negedge clk);
    end
    if (ok) exp_q.push_back(model(x, y, ci, sb));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); n++;
    end
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: got %h want none", {Carry_Out, Sum});
      end else begin
        check("result", {Carry_Out, Sum}, exp_q.pop_front());
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    logic [W-1:0] held;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; Carry_In = 1'b0; sub_v = 1'b0;
    out_ready = 1'b1; done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", Sum, 0);
    check("rst_cout", Carry_Out, 0);
    check("rst_in_ready", in_ready, 1);

    // single op and its latency
    send(16'h0005, 16'h0009, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("latency_early", out_valid, 0);
    @(posedge clk); #1;
    check("latency_on", out_valid, 1);
    check("single_sum", {Carry_Out, Sum}, 17'h0000E);
    wait_drain();

    // full carry chain
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    wait_drain();

    // streaming
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) send(W'(i), W'(i), 1'b0, 1'b0);
    wait_drain();
    check("stream_count", pop_cyc.size(), 8);
    for (int i = 1; i < pop_cyc.size(); i++)
      check("stream_gap", pop_cyc[i] - pop_cyc[i-1], 1);

    // backpressure with a full pipe
    fork
      for (int i = 0; i < 10; i++) send(W'(16'h0100 + i), W'(16'h00F0 * i), i[0], 1'b0);
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        held = Sum;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_valid", out_valid, 1);
          check("stall_sum_held", Sum, held);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // reset mid-stream
    for (int i = 0; i < 3; i++) send(W'(16'h1000 + i), W'(16'h0011), 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("midrst_valid", out_valid, 0);
    repeat (10) @(posedge clk);
    #1 check("midrst_quiet", out_valid, 0);

`ifdef PIPE_ADDER_SUB_EN
    send(16'd10, 16'd5, 1'b0, 1'b1);
    send(16'd5, 16'd10, 1'b1, 1'b1);
    wait_drain();
`endif

    // random traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
`ifdef PIPE_ADDER_SUB_EN
          send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
`else
          send(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
`endif
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
